// File: rtl/shift_arb_pkg.sv
// Shared types and width helpers for the shift-register output arbiter.
package shift_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch,
        StDone
    } state_e;

    function automatic int unsigned phase_w(input int unsigned clk_div);
        return $clog2(clk_div) + 1;
    endfunction

    function automatic int unsigned bit_w(input int unsigned data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/shift_arb_picker.sv
// Requester selection: round-robin from a pointer, or fixed lowest-index priority
// when SHIFT_ARB_FIXED_PRIO_EN is defined.
module shift_arb_picker #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    input  logic [NUM_REQ-1:0] winner,
    output logic [NUM_REQ-1:0] pick
);

`ifdef SHIFT_ARB_FIXED_PRIO_EN

    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, update, winner};

    // Isolate the lowest set bit.
    assign pick = req & (~req + NUM_REQ'(1));

`else

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] mask, masked;

    // Prefer requesters at or above the pointer; wrap to the full set otherwise.
    always_comb begin
        mask = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            mask[j] = (j >= int'(ptr_q));
        end
        masked = req & mask;
        if (|masked) begin
            pick = masked & (~masked + NUM_REQ'(1));
        end else begin
            pick = req & (~req + NUM_REQ'(1));
        end
    end

    always_comb begin
        win_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner[j]) begin
                win_idx = PTR_W'(j);
            end
        end
        ptr_d = ptr_q;
        if (update) begin
            ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/shift_out_arbiter.sv
// Arbitrates requesters onto one 74HC595-style chain, shifts the word MSB-first, latches, acks.
// Define SHIFT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module shift_out_arbiter
    import shift_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      serialData,
    output logic                      shiftClk,
    output logic                      latchClk
);

    localparam int unsigned PHASE_W = phase_w(CLK_DIV);
    localparam int unsigned BIT_W   = bit_w(DATA_W);
    localparam logic [PHASE_W-1:0] PhaseLast = PHASE_W'(CLK_DIV - 1);

    state_e              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                high_q, high_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [NUM_REQ-1:0]  grant_d, ack_d;
    logic                busy_d, ser_d, sclk_d, lclk_d;
    logic [NUM_REQ-1:0]  pick;
    logic [DATA_W-1:0]   pick_word;
    logic [DATA_W-1:0]   shifted;

    shift_arb_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .update (state_q == StDone),
        .winner (ack),
        .pick   (pick)
    );

    always_comb begin
        pick_word = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick[j]) begin
                pick_word = reqData[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        high_d   = high_q;
        shadow_d = shadow_q;
        grant_d  = grant;
        ack_d    = '0;

        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d  = StShift;
                    shadow_d = pick_word;
                    grant_d  = pick;
                    phase_d  = '0;
                    high_d   = 1'b0;
                    bit_d    = BIT_W'(DATA_W - 1);
                end
            end
            StShift: begin
                if (phase_q == PhaseLast) begin
                    phase_d = '0;
                    if (!high_q) begin
                        high_d = 1'b1;
                    end else begin
                        high_d = 1'b0;
                        if (bit_q == '0) begin
                            state_d = StLatch;
                        end else begin
                            bit_d = bit_q - BIT_W'(1);
                        end
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            StLatch: begin
                if (phase_q == PhaseLast) begin
                    phase_d = '0;
                    state_d = StDone;
                    ack_d   = grant;
                    grant_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Pin values are derived from the next state so every output comes straight off a flop.
        shifted = shadow_d >> bit_d;
        busy_d  = (state_d != StIdle);
        ser_d   = (state_d == StShift) && shifted[0];
        sclk_d  = (state_d == StShift) && high_d;
        lclk_d  = (state_d == StLatch);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            bit_q      <= '0;
            high_q     <= 1'b0;
            shadow_q   <= '0;
            grant      <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            serialData <= 1'b0;
            shiftClk   <= 1'b0;
            latchClk   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            high_q     <= high_d;
            shadow_q   <= shadow_d;
            grant      <= grant_d;
            ack        <= ack_d;
            busy       <= busy_d;
            serialData <= ser_d;
            shiftClk   <= sclk_d;
            latchClk   <= lclk_d;
        end
    end

endmodule

// File: tb/tb_shift_out_arbiter.sv
// Self-checking bench for shift_out_arbiter: per-cycle pin waveform against a cycle-index model.
module tb_shift_out_arbiter;

    localparam int NR   = 2;
    localparam int DW   = 8;
    localparam int CD   = 2;
    localparam int XFER = 2 * CD * DW + CD + 1;
    localparam int OW   = 2 * NR + 4;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] reqData;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    grant;
    logic             busy;
    logic             serialData;
    logic             shiftClk;
    logic             latchClk;
    logic [OW-1:0]    obs;

    int n_cmp;
    int n_bad;
    int rr_ptr;

    shift_out_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .CLK_DIV (CD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .reqData    (reqData),
        .ack        (ack),
        .grant      (grant),
        .busy       (busy),
        .serialData (serialData),
        .shiftClk   (shiftClk),
        .latchClk   (latchClk)
    );

    assign obs = {ack, grant, busy, serialData, shiftClk, latchClk};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OW-1:0] o, input logic [OW-1:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    // First requester at or after the pointer, scanning upward with wrap.
    function automatic int model_pick(input logic [NR-1:0] r, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (r[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return 0;
    endfunction

    // Expected pins in cycle c (1 = first cycle after the grant edge).
    function automatic logic [OW-1:0] exp_out(input int c, input int g, input logic [DW-1:0] w);
        logic [NR-1:0] oh;
        logic [NR-1:0] z;
        int            b;
        logic          hi;
        oh = '0;
        oh[g] = 1'b1;
        z = '0;
        if (c <= 2 * CD * DW) begin
            b  = DW - 1 - (c - 1) / (2 * CD);
            hi = ((c - 1) % (2 * CD)) >= CD;
            return {z, oh, 1'b1, w[b], hi, 1'b0};
        end
        if (c < XFER) return {z, oh, 1'b1, 1'b0, 1'b0, 1'b1};
        return {oh, z, 1'b1, 3'b000};
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        reqData = '0;
        #1;
        check("reset_async", obs, '0);
        repeat (2) @(negedge clk);
        check("reset_hold", obs, '0);
        reset  = 1'b0;
        rr_ptr = 0;
    endtask

    // Runs one transfer from the next grant edge; req must already be set.
    task automatic run_xfer(input string tag, input bit clear_on_ack, input int change_at,
                            input logic [NR*DW-1:0] new_data, input int drop_at,
                            input logic [NR-1:0] drop_mask, input int abort_at);
        int            g;
        logic [DW-1:0] w;
        g = model_pick(req, rr_ptr);
        w = reqData[g*DW +: DW];
        for (int c = 1; c <= XFER; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                reset = 1'b1;
                req   = '0;
                #1;
                check({tag, "_abort"}, obs, '0);
                rr_ptr = 0;
                return;
            end
            check(tag, obs, exp_out(c, g, w));
            if (c == change_at) reqData = new_data;
            if (c == drop_at) req = req & ~drop_mask;
            if (c == XFER && clear_on_ack) req[g] = 1'b0;
        end
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        rr_ptr = 0;
`else
        rr_ptr = (g + 1) % NR;
`endif
        @(negedge clk);
        check({tag, "_gap"}, obs, '0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rr_ptr  = 0;
        reset   = 1'b1;
        req     = '0;
        reqData = '0;
        @(negedge clk);

        // Single request, A5 on requester 0.
        do_reset();
        reqData = {8'h00, 8'hA5};
        req     = 2'b01;
        run_xfer("single_a5", 1'b1, 0, '0, 0, '0, 0);

        // Simultaneous requests from reset: 0 then 1, then silence.
        do_reset();
        reqData = {8'h3C, 8'hC3};
        req     = 2'b11;
        run_xfer("simul_first", 1'b1, 0, '0, 0, '0, 0);
        run_xfer("simul_second", 1'b1, 0, '0, 0, '0, 0);
        repeat (4) begin
            @(negedge clk);
            check("simul_quiet", obs, '0);
        end

        // Both held for four transfers.
        do_reset();
        reqData = {8'h5A, 8'h81};
        req     = 2'b11;
        repeat (4) run_xfer("fairness", 1'b0, 0, '0, 0, '0, 0);
        req = '0;

        // Data changes one cycle into SHIFT; captured word must be shifted.
        do_reset();
        reqData = {8'h00, 8'h0F};
        req     = 2'b01;
        run_xfer("data_change", 1'b1, 1, {8'h00, 8'hF0}, 0, '0, 0);

        // Reset asserted while bit 4 is on the wire.
        do_reset();
        reqData = {8'h00, 8'hFF};
        req     = 2'b01;
        run_xfer("rst_mid", 1'b1, 0, '0, 0, '0, 14);
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_held", obs, '0);
        end
        reset   = 1'b0;
        reqData = {8'h3C, 8'h00};
        req     = 2'b10;
        run_xfer("after_rst", 1'b1, 0, '0, 0, '0, 0);

        // Requester 1 withdraws mid-transfer.
        do_reset();
        reqData = {8'h96, 8'h00};
        req     = 2'b10;
        run_xfer("withdraw", 1'b1, 0, '0, 5, 2'b10, 0);

        // Randomized traffic with mid-transfer data churn and withdrawals.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            req     = NR'($urandom_range(1, (1 << NR) - 1));
            reqData = (NR*DW)'($urandom);
            run_xfer("random", 1'($urandom_range(0, 1)), $urandom_range(1, XFER - 1),
                     (NR*DW)'($urandom), $urandom_range(0, XFER - 1),
                     NR'($urandom_range(0, (1 << NR) - 1)), 0);
        end
        req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
